// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : BCD MM:SS countdown timer. Tick (1 Hz square wave) is
//                sampled as a level in the Clk domain; its rising edge
//                produces a one-cycle second pulse that decrements the count
//                while running. Start/Stop/Clear/Load control, Done/Alarm
//                at 00:00.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int MAXMINT = 5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    input  logic       Load,
    input  logic [3:0] LdMinT,
    input  logic [3:0] LdMinO,
    input  logic [3:0] LdSecT,
    input  logic [3:0] LdSecO,
    output logic [3:0] MinT,
    output logic [3:0] MinO,
    output logic [3:0] SecT,
    output logic [3:0] SecO,
    output logic [1:0] State,
    output logic       Running,
    output logic       Done,
    output logic       Alarm
);

    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_RUN   = 2'b01;
    localparam logic [1:0] c_ST_PAUSE = 2'b10;
    localparam logic [1:0] c_ST_DONE  = 2'b11;

    localparam logic [3:0] c_MAX_MIN_T = 4'(MAXMINT);

    logic       r_tickQ;
    logic [1:0] r_state;
    logic [3:0] r_minT, r_minO, r_secT, r_secO;

    logic       w_secPulse;
    logic       w_isZero;
    logic       w_isOne;
    logic [3:0] w_ldMinT, w_ldMinO, w_ldSecT, w_ldSecO;
    logic [3:0] w_decMinT, w_decMinO, w_decSecT, w_decSecO;

    assign w_secPulse = Tick & ~r_tickQ;
    assign w_isZero   = (r_minT == 4'd0) && (r_minO == 4'd0) &&
                        (r_secT == 4'd0) && (r_secO == 4'd0);
    assign w_isOne    = (r_minT == 4'd0) && (r_minO == 4'd0) &&
                        (r_secT == 4'd0) && (r_secO == 4'd1);

    // Clamp preset digits so the count is always legal BCD
    always_comb begin
        w_ldMinT = (LdMinT > c_MAX_MIN_T) ? c_MAX_MIN_T : LdMinT;
        w_ldMinO = (LdMinO > 4'd9) ? 4'd9 : LdMinO;
        w_ldSecT = (LdSecT > 4'd5) ? 4'd5 : LdSecT;
        w_ldSecO = (LdSecO > 4'd9) ? 4'd9 : LdSecO;
    end

    // One-second BCD decrement with borrow chain SecO -> SecT -> MinO -> MinT
    always_comb begin
        w_decSecO = r_secO - 4'd1;
        w_decSecT = r_secT;
        w_decMinO = r_minO;
        w_decMinT = r_minT;
        if (r_secO == 4'd0) begin
            w_decSecO = 4'd9;
            if (r_secT == 4'd0) begin
                w_decSecT = 4'd5;
                if (r_minO == 4'd0) begin
                    w_decMinO = 4'd9;
                    w_decMinT = r_minT - 4'd1;
                end else begin
                    w_decMinO = r_minO - 4'd1;
                end
            end else begin
                w_decSecT = r_secT - 4'd1;
            end
        end
    end

    // Tick edge detector, active in every state
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_tickQ <= 1'b0;
        end else begin
            r_tickQ <= Tick;
        end
    end

    // Control FSM and count register; Clear > Load > Stop > Start
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_ST_IDLE;
            r_minT  <= 4'd0;
            r_minO  <= 4'd0;
            r_secT  <= 4'd0;
            r_secO  <= 4'd0;
        end else if (Clear) begin
            r_state <= c_ST_IDLE;
            r_minT  <= 4'd0;
            r_minO  <= 4'd0;
            r_secT  <= 4'd0;
            r_secO  <= 4'd0;
        end else if (Load) begin
            r_state <= c_ST_IDLE;
            r_minT  <= w_ldMinT;
            r_minO  <= w_ldMinO;
            r_secT  <= w_ldSecT;
            r_secO  <= w_ldSecO;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!Stop && Start && !w_isZero) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (Stop) begin
                        r_state <= c_ST_PAUSE;
                    end else if (w_secPulse) begin
                        r_minT <= w_decMinT;
                        r_minO <= w_decMinO;
                        r_secT <= w_decSecT;
                        r_secO <= w_decSecO;
                        if (w_isOne) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_PAUSE: begin
                    if (!Stop && Start) begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    r_state <= c_ST_DONE;
                end
            endcase
        end
    end

    assign MinT    = r_minT;
    assign MinO    = r_minO;
    assign SecT    = r_secT;
    assign SecO    = r_secO;
    assign State   = r_state;
    assign Running = (r_state == c_ST_RUN);
    assign Done    = (r_state == c_ST_DONE);
    assign Alarm   = Done & Tick;

endmodule
`default_nettype wire
